// File: rtl/zoom_level_if.sv
// Board-side and scaler-side signals of the zoom-level selector.
// The controller drives the zoom outputs and upd_valid; buttons, switches and upd_ready come from outside.
interface zoom_level_if #(
   parameter int LVL_W = 3,
   parameter int ALG_W = 3
);
   logic [ALG_W-1:0] escolha_alg;
   logic             but_zoom_in;
   logic             but_zoom_out;
   logic [LVL_W-1:0] level;
   logic             zoom_dir;
   logic [LVL_W-2:0] zoom_mag;
   logic             at_max;
   logic             at_min;
   logic             upd_valid;
   logic             upd_ready;

   modport master (
      input  escolha_alg, but_zoom_in, but_zoom_out, upd_ready,
      output level, zoom_dir, zoom_mag, at_max, at_min, upd_valid
   );

   modport slave (
      output escolha_alg, but_zoom_in, but_zoom_out, upd_ready,
      input  level, zoom_dir, zoom_mag, at_max, at_min, upd_valid
   );
endinterface

// File: rtl/zoom_level_ctrl.sv
// Zoom-level selector: debounced, auto-repeating zoom buttons drive a saturating signed level
// that is offered to the image scaler over a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | no update pending; button events and algorithm changes are evaluated
// ST_OFFER | level offered to scaler (upd_valid=1); outputs frozen, button events dropped
module zoom_level_ctrl #(
   parameter int N_UP       = 2,
   parameter int N_DOWN     = 2,
   parameter int LVL_W      = 3,
   parameter int ALG_W      = 3,
   parameter int DEB_CYCLES = 500000,
   parameter int RPT_DELAY  = 25000000,
   parameter int RPT_PERIOD = 10000000
) (
   input logic          clk,
   input logic          rst,
   zoom_level_if.master bus
);

   localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic signed [LVL_W-1:0] LVL_MAX = LVL_W'(N_UP);
   localparam logic signed [LVL_W-1:0] LVL_MIN = LVL_W'(-N_DOWN);

   typedef enum logic {ST_IDLE, ST_OFFER} state_t;

   // Index 0 is zoom-in, index 1 is zoom-out throughout.
   logic [1:0]              btn_raw;
   logic [1:0]              btn_s1_q, btn_s2_q;
   logic [1:0]              deb_q, deb_d, deb_prev_q;
   logic [DEB_W-1:0]        deb_cnt_q [2];
   logic [DEB_W-1:0]        deb_cnt_d [2];
   logic [RPT_W-1:0]        hold_cnt_q [2];
   logic [RPT_W-1:0]        hold_cnt_d [2];
   logic [1:0]              ev;
   logic [ALG_W-1:0]        alg_s1_q, alg_s2_q, alg_prev_q;
   logic [1:0]              win_cnt_q;
   logic                    alg_chg;
   state_t                  state_q, state_d;
   logic                    defer_q, defer_d;
   logic signed [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0]        lvl_neg;
   logic [LVL_W-2:0]        mag_q, mag_d;
   logic                    dir_q, at_max_q, at_min_q;

   assign btn_raw = {bus.but_zoom_out, bus.but_zoom_in};

   // Down-counting hold timer: press loads RPT_DELAY-1, each repeat reloads RPT_PERIOD-1.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         deb_d[b]      = deb_q[b];
         deb_cnt_d[b]  = '0;
         hold_cnt_d[b] = '0;
         ev[b]         = 1'b0;
         if (btn_s2_q[b] != deb_q[b]) begin
            if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
               deb_d[b] = btn_s2_q[b];
            end else begin
               deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
            end
         end
         if (!deb_q[b]) begin
            if (deb_prev_q[b]) begin
               ev[b]         = 1'b1;
               hold_cnt_d[b] = RPT_W'(RPT_DELAY - 1);
            end else if (hold_cnt_q[b] == '0) begin
               ev[b]         = 1'b1;
               hold_cnt_d[b] = RPT_W'(RPT_PERIOD - 1);
            end else begin
               hold_cnt_d[b] = hold_cnt_q[b] - 1'b1;
            end
         end
      end
   end

   assign alg_chg = (win_cnt_q == 2'd3) && (alg_s2_q != alg_prev_q);

   always_comb begin
      state_d = state_q;
      defer_d = defer_q;
      level_d = level_q;
      case (state_q)
         ST_IDLE: begin
            if (defer_q || alg_chg) begin
               level_d = '0;
               defer_d = 1'b0;
               state_d = ST_OFFER;
            end else if (ev[0] != ev[1]) begin
               if (ev[0] && level_q != LVL_MAX) begin
                  level_d = level_q + LVL_W'(1);
                  state_d = ST_OFFER;
               end else if (ev[1] && level_q != LVL_MIN) begin
                  level_d = level_q - LVL_W'(1);
                  state_d = ST_OFFER;
               end
            end
         end
         ST_OFFER: begin
            if (alg_chg) defer_d = 1'b1;
            if (bus.upd_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lvl_neg = -level_d;
      mag_d   = level_d[LVL_W-1] ? lvl_neg[LVL_W-2:0] : level_d[LVL_W-2:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q   <= 2'b11;
         btn_s2_q   <= 2'b11;
         deb_q      <= 2'b11;
         deb_prev_q <= 2'b11;
         for (int b = 0; b < 2; b++) begin
            deb_cnt_q[b]  <= '0;
            hold_cnt_q[b] <= '0;
         end
         alg_s1_q   <= '0;
         alg_s2_q   <= '0;
         alg_prev_q <= '0;
         win_cnt_q  <= '0;
         state_q    <= ST_IDLE;
         defer_q    <= 1'b0;
         level_q    <= '0;
         mag_q      <= '0;
         dir_q      <= 1'b0;
         at_max_q   <= 1'b0;
         at_min_q   <= 1'b0;
      end else begin
         btn_s1_q   <= btn_raw;
         btn_s2_q   <= btn_s1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int b = 0; b < 2; b++) begin
            deb_cnt_q[b]  <= deb_cnt_d[b];
            hold_cnt_q[b] <= hold_cnt_d[b];
         end
         alg_s1_q   <= bus.escolha_alg;
         alg_s2_q   <= alg_s1_q;
         alg_prev_q <= alg_s2_q;
         if (win_cnt_q != 2'd3) win_cnt_q <= win_cnt_q + 2'd1;
         state_q    <= state_d;
         defer_q    <= defer_d;
         level_q    <= level_d;
         mag_q      <= mag_d;
         dir_q      <= level_d[LVL_W-1];
         at_max_q   <= (level_d == LVL_MAX);
         at_min_q   <= (level_d == LVL_MIN);
      end
   end

   always_comb begin
      bus.upd_valid = (state_q == ST_OFFER);
      bus.level     = level_q;
      bus.zoom_dir  = dir_q;
      bus.zoom_mag  = mag_q;
      bus.at_max    = at_max_q;
      bus.at_min    = at_min_q;
   end

endmodule

// File: tb/tb_zoom_level_ctrl.sv
// Directed bench for zoom_level_ctrl with short debounce/repeat timing.
module tb_zoom_level_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   vld_cnt = 0;
   int   base;

   always #5 clk = ~clk;

   zoom_level_if #(.LVL_W(3), .ALG_W(3)) bus ();

   zoom_level_ctrl #(
      .N_UP(2), .N_DOWN(2), .LVL_W(3), .ALG_W(3),
      .DEB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(negedge clk) if (bus.upd_valid === 1'b1) vld_cnt++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input bit p_in, input bit p_out, input int hold);
      if (p_in)  bus.but_zoom_in  = 1'b0;
      if (p_out) bus.but_zoom_out = 1'b0;
      tick(hold);
      bus.but_zoom_in  = 1'b1;
      bus.but_zoom_out = 1'b1;
      tick(20);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(5);
   endtask

   function automatic int lvl();
      return int'($signed(bus.level));
   endfunction

   initial begin
      bus.escolha_alg  = 3'b000;
      bus.but_zoom_in  = 1'b1;
      bus.but_zoom_out = 1'b1;
      bus.upd_ready    = 1'b1;
      tick(3);
      chk("rst_level", lvl(), 0);
      chk("rst_dir", int'(bus.zoom_dir), 0);
      chk("rst_mag", int'(bus.zoom_mag), 0);
      chk("rst_max", int'(bus.at_max), 0);
      chk("rst_min", int'(bus.at_min), 0);
      chk("rst_valid", int'(bus.upd_valid), 0);
      rst = 1'b0;
      tick(5);

      // clean press: 2 sync + 4 debounce to event, +1 to upd_valid
      base = vld_cnt;
      bus.but_zoom_in = 1'b0;
      tick(6);
      chk("lat_valid_early", int'(bus.upd_valid), 0);
      tick(1);
      chk("lat_valid", int'(bus.upd_valid), 1);
      chk("lat_level", lvl(), 1);
      tick(1);
      chk("lat_valid_fall", int'(bus.upd_valid), 0);
      tick(2);
      bus.but_zoom_in = 1'b1;
      tick(20);
      chk("press_pulses", vld_cnt - base, 1);
      chk("press_level", lvl(), 1);
      chk("press_mag", int'(bus.zoom_mag), 1);
      chk("press_dir", int'(bus.zoom_dir), 0);

      // bounce then hold: one press, repeat at +20 reaches max, +28 saturated
      pulse_rst();
      base = vld_cnt;
      bus.but_zoom_in = 1'b0; tick(2);
      bus.but_zoom_in = 1'b1; tick(2);
      bus.but_zoom_in = 1'b0; tick(2);
      bus.but_zoom_in = 1'b1; tick(2);
      bus.but_zoom_in = 1'b0;
      tick(7);
      chk("bounce_valid", int'(bus.upd_valid), 1);
      chk("bounce_level", lvl(), 1);
      tick(19);
      chk("rpt1_early", int'(bus.upd_valid), 0);
      tick(1);
      chk("rpt1_valid", int'(bus.upd_valid), 1);
      chk("rpt1_level", lvl(), 2);
      chk("rpt1_at_max", int'(bus.at_max), 1);
      tick(8);
      chk("rpt2_sat_valid", int'(bus.upd_valid), 0);
      tick(10);
      bus.but_zoom_in = 1'b1;
      tick(15);
      chk("hold_pulses", vld_cnt - base, 2);
      chk("hold_level", lvl(), 2);

      // zoom-out to the minimum
      pulse_rst();
      base = vld_cnt;
      press(1'b0, 1'b1, 10);
      chk("out1_level", lvl(), -1);
      press(1'b0, 1'b1, 10);
      chk("out2_level", lvl(), -2);
      press(1'b0, 1'b1, 10);
      chk("out3_level", lvl(), -2);
      chk("out_at_min", int'(bus.at_min), 1);
      chk("out_dir", int'(bus.zoom_dir), 1);
      chk("out_mag", int'(bus.zoom_mag), 2);
      chk("out_pulses", vld_cnt - base, 2);

      // simultaneous presses cancel
      base = vld_cnt;
      press(1'b1, 1'b1, 10);
      chk("both_level", lvl(), -2);
      chk("both_pulses", vld_cnt - base, 0);

      // stalled scaler: dropped press, deferred algorithm reset
      pulse_rst();
      bus.upd_ready = 1'b0;
      press(1'b1, 1'b0, 10);
      chk("stall_level", lvl(), 1);
      chk("stall_valid", int'(bus.upd_valid), 1);
      press(1'b1, 1'b0, 10);
      chk("drop_level", lvl(), 1);
      bus.escolha_alg = 3'b101;
      tick(10);
      chk("defer_hold_level", lvl(), 1);
      chk("defer_hold_valid", int'(bus.upd_valid), 1);
      bus.upd_ready = 1'b1;
      tick(1);
      bus.upd_ready = 1'b0;
      chk("hs_gap_valid", int'(bus.upd_valid), 0);
      chk("hs_gap_level", lvl(), 1);
      tick(1);
      chk("defer_valid", int'(bus.upd_valid), 1);
      chk("defer_level", lvl(), 0);
      bus.upd_ready = 1'b1;
      tick(2);
      chk("defer_done", int'(bus.upd_valid), 0);

      // reset from level 2; alg change in the post-reset window is ignored
      press(1'b1, 1'b0, 10);
      press(1'b1, 1'b0, 10);
      chk("pre_rst_level", lvl(), 2);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_level", lvl(), 0);
      chk("mid_rst_valid", int'(bus.upd_valid), 0);
      rst = 1'b0;
      bus.escolha_alg = 3'b010;
      base = vld_cnt;
      tick(10);
      chk("win_pulses", vld_cnt - base, 0);
      chk("win_level", lvl(), 0);

      // alg change at level 0 is still offered
      base = vld_cnt;
      bus.escolha_alg = 3'b011;
      tick(10);
      chk("alg0_pulses", vld_cnt - base, 1);
      chk("alg0_level", lvl(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
